parking_sensor_emulator: RTL and testbench
==========================================

Name: parking_sensor_emulator

Overview:
- Drives the two parking-lot sensor pairs 'a' and 'b' with the exact gray-coded crossing patterns a real car produces.
- Turns one-cycle "car enters" / "car exits" requests into timed A/B waveforms.
- Used on the EDU-CIAA-FPGA for hardware-in-the-loop checks of the occupancy counter and for bench stimulus.
- Keeps a shadow occupancy count so the count shown on the counter's LEDs can be cross-checked.

Parameters:
DWELL_CYCLES, 5, clock cycles each non-idle sensor phase is held (≥1)
GAP_CYCLES, 5, clock cycles A=B=0 is held after the third phase before the next car (≥1)
OCC_W, 3, width of the shadow occupancy count
MAX_OCC, 7, occupancy ceiling (≤ 2^OCC_W−1)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  synchronous, active-low reset
REQ_ENTER  in  1  request one entering car; sampled only when READY=1
REQ_EXIT  in  1  request one exiting car; sampled only when READY=1
A  out  1  sensor-pair 'a' drive, registered
B  out  1  sensor-pair 'b' drive, registered
READY  out  1  high in IDLE; a request may be accepted
BUSY  out  1  high while a sequence (phases + gap) is running
DIR  out  1  direction of the running or last sequence; 1=enter, 0=exit
DONE  out  1  one-cycle pulse when a sequence completes
REJECT  out  1  one-cycle pulse when an IDLE request is refused
OCC  out  OCC_W  shadow occupancy count

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - State goes to IDLE; dwell counter clears.
  - A=0, B=0, BUSY=0, READY=1, DONE=0, REJECT=0, DIR=0, OCC=0.
  - Reset mid-sequence aborts at that edge; no DONE is issued and OCC is unchanged from reset value 0.
- States: IDLE, PH1, PH2, PH3, GAP.
- Enter pattern (A,B): PH1=10, PH2=11, PH3=01, GAP=00.
- Exit pattern (A,B): PH1=01, PH2=11, PH3=10, GAP=00.
- IDLE: A=B=0, READY=1, BUSY=0.
- Acceptance, at a rising edge in IDLE:
  - REQ_ENTER=1, REQ_EXIT=0, OCC<MAX_OCC → go to PH1 with DIR=1.
  - REQ_EXIT=1, REQ_ENTER=0, OCC>0 → go to PH1 with DIR=0.
  - Both requests high, enter with OCC==MAX_OCC, or exit with OCC==0 → stay IDLE, REJECT=1 for the next cycle, OCC unchanged.
- Sequencing:
  - The first PH1 output appears in the cycle after acceptance (1-cycle latency).
  - PH1, PH2 and PH3 each last exactly DWELL_CYCLES cycles; GAP lasts exactly GAP_CYCLES cycles.
  - Busy duration is 3·DWELL_CYCLES+GAP_CYCLES cycles.
  - A and B are registered; only one of them changes at any phase boundary (glitch-free, gray order).
- Completion:
  - On the edge leaving GAP, return to IDLE.
  - In that first IDLE cycle: DONE=1, and OCC has been updated by +1 (DIR=1) or −1 (DIR=0).
  - READY=1 in the same cycle as DONE, so back-to-back requests are possible.
- Requests while BUSY are ignored: no REJECT, not queued.
- The dwell counter is sized as ceil(log2(max(DWELL_CYCLES,GAP_CYCLES)+1)) bits and is reloaded on every state change.
- OCC never wraps; the bounds are enforced at acceptance.
- DIR holds its value in IDLE.

Test Plan:
1. Reset, then a REQ_ENTER pulse in cycle 0 → cycles 1–5 AB=10, 6–10 AB=11, 11–15 AB=01, 16–20 AB=00 with BUSY=1; cycle 21 DONE=1, READY=1, OCC=1, DIR=1.
2. From OCC=1, a REQ_EXIT pulse → AB sequence 01, 11, 10, 00 at 5 cycles each; then DONE=1 and OCC=0, DIR=0.
3. Seven back-to-back enters, each issued in the DONE cycle → OCC=7 after the 7th DONE; an 8th REQ_ENTER gives REJECT=1 for one cycle, AB stays 00, OCC=7.
4. At OCC=0, REQ_EXIT → REJECT pulse, OCC=0. REQ_ENTER and REQ_EXIT high together → REJECT pulse, no sequence.
5. REQ_ENTER accepted; REQ_EXIT pulsed during PH2 → ignored: no REJECT, enter sequence completes unchanged, OCC +1.
6. RST_N=0 for one edge during PH2 (AB=11) → next cycle AB=00, BUSY=0, READY=1, OCC=0, no DONE; a new REQ_ENTER then runs a normal full sequence.

Source files
------------

// File: rtl/parking_sensor_emulator.sv
// Parking-lot sensor emulator: turns enter/exit requests into gray-coded A/B crossing
// waveforms and keeps a shadow occupancy count for cross-checking the real counter.
module parking_sensor_emulator #(
  parameter int unsigned DWELL_CYCLES = 5,
  parameter int unsigned GAP_CYCLES   = 5,
  parameter int unsigned OCC_W        = 3,
  parameter int unsigned MAX_OCC      = 7
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_ENTER,
  input  logic             REQ_EXIT,
  output logic             A,
  output logic             B,
  output logic             READY,
  output logic             BUSY,
  output logic             DIR,
  output logic             DONE,
  output logic             REJECT,
  output logic [OCC_W-1:0] OCC
);

  localparam int unsigned MaxHold = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxHold + 1);

  localparam logic [CntW-1:0]  DwellLoad = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0]  GapLoad   = CntW'(GAP_CYCLES - 1);
  localparam logic [OCC_W-1:0] OccMax    = OCC_W'(MAX_OCC);

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StGap} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             can_enter, can_exit;

  assign can_enter = (occ_q != OccMax);
  assign can_exit  = (occ_q != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    reject_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (REQ_ENTER && !REQ_EXIT && can_enter) begin
          state_d = StPh1;
          cnt_d   = DwellLoad;
          dir_d   = 1'b1;
        end else if (REQ_EXIT && !REQ_ENTER && can_exit) begin
          state_d = StPh1;
          cnt_d   = DwellLoad;
          dir_d   = 1'b0;
        end else if (REQ_ENTER || REQ_EXIT) begin
          reject_d = 1'b1;
        end
      end
      StPh1: begin
        if (cnt_q == '0) begin
          state_d = StPh2;
          cnt_d   = DwellLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPh2: begin
        if (cnt_q == '0) begin
          state_d = StPh3;
          cnt_d   = DwellLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPh3: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
          occ_d   = dir_q ? (occ_q + OCC_W'(1)) : (occ_q - OCC_W'(1));
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // A/B derive from the next state so the sensor lines change in the same edge as the state.
  always_comb begin
    a_d = 1'b0;
    b_d = 1'b0;
    case (state_d)
      StPh1: begin
        a_d = dir_d;
        b_d = !dir_d;
      end
      StPh2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      StPh3: begin
        a_d = !dir_d;
        b_d = dir_d;
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      occ_q    <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign READY  = (state_q == StIdle);
  assign BUSY   = (state_q != StIdle);
  assign DIR    = dir_q;
  assign DONE   = done_q;
  assign REJECT = reject_q;
  assign OCC    = occ_q;

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Scoreboard bench: requests push expected DONE/REJECT events; a negedge monitor pops
// and compares them, including the A/B trace recorded while BUSY.
module tb_parking_sensor_emulator;

  localparam int Dwell = 5;
  localparam int Gap   = 5;
  localparam int MaxO  = 7;

  logic       CLK;
  logic       RST_N;
  logic       REQ_ENTER;
  logic       REQ_EXIT;
  logic       A;
  logic       B;
  logic       READY;
  logic       BUSY;
  logic       DIR;
  logic       DONE;
  logic       REJECT;
  logic [2:0] OCC;

  parking_sensor_emulator #(
    .DWELL_CYCLES(Dwell),
    .GAP_CYCLES  (Gap),
    .OCC_W       (3),
    .MAX_OCC     (MaxO)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ_ENTER(REQ_ENTER),
    .REQ_EXIT (REQ_EXIT),
    .A        (A),
    .B        (B),
    .READY    (READY),
    .BUSY     (BUSY),
    .DIR      (DIR),
    .DONE     (DONE),
    .REJECT   (REJECT),
    .OCC      (OCC)
  );

  typedef struct {
    bit          is_reject;
    logic [2:0]  occ;
    logic        dir;
    logic [63:0] trace;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   occ_m  = 0;
  bit   dir_m  = 1'b0;

  logic [63:0] mon_trace = '0;
  int          mon_len   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected A/B trace over the busy window, two bits per cycle, oldest first.
  function automatic logic [63:0] mk_trace(input bit dir);
    logic [63:0] t;
    logic [1:0]  ab;
    int          n;
    t = '0;
    for (int p = 0; p < 4; p++) begin
      case (p)
        0:       ab = dir ? 2'b10 : 2'b01;
        1:       ab = 2'b11;
        2:       ab = dir ? 2'b01 : 2'b10;
        default: ab = 2'b00;
      endcase
      n = (p == 3) ? Gap : Dwell;
      for (int i = 0; i < n; i++) t = {t[61:0], ab};
    end
    return t;
  endfunction

  // Called #1 after a rising edge; waits for READY, then drives the request for one cycle.
  task automatic issue(input bit en, input bit ex, input bit expect_evt);
    int   n;
    exp_t e;
    n = 0;
    while (!READY && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!READY) begin
      check("ready_timeout", {63'd0, READY}, 64'd1);
      return;
    end
    e.trace = '0;
    e.len   = 0;
    if (en && !ex && occ_m < MaxO) begin
      occ_m++;
      dir_m       = 1'b1;
      e.is_reject = 1'b0;
      e.trace     = mk_trace(1'b1);
      e.len       = 3 * Dwell + Gap;
    end else if (ex && !en && occ_m > 0) begin
      occ_m--;
      dir_m       = 1'b0;
      e.is_reject = 1'b0;
      e.trace     = mk_trace(1'b0);
      e.len       = 3 * Dwell + Gap;
    end else begin
      e.is_reject = 1'b1;
    end
    e.occ = 3'(occ_m);
    e.dir = dir_m;
    if (expect_evt) sb.push_back(e);
    REQ_ENTER = en;
    REQ_EXIT  = ex;
    @(posedge CLK);
    #1;
    REQ_ENTER = 1'b0;
    REQ_EXIT  = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      mon_trace = '0;
      mon_len   = 0;
    end else begin
      if (BUSY === 1'b1) begin
        mon_trace = {mon_trace[61:0], A, B};
        mon_len++;
      end
      if (DONE === 1'b1 || REJECT === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {62'd0, DONE, REJECT}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("event_kind", {63'd0, REJECT}, {63'd0, e.is_reject});
          check("event_done", {63'd0, DONE}, {63'd0, !e.is_reject});
          check("event_occ", {61'd0, OCC}, {61'd0, e.occ});
          check("event_dir", {63'd0, DIR}, {63'd0, e.dir});
          check("event_ready", {63'd0, READY}, 64'd1);
          check("event_ab", {62'd0, A, B}, 64'd0);
          if (!e.is_reject) begin
            check("busy_len", 64'(mon_len), 64'(e.len));
            check("ab_trace", mon_trace, e.trace);
          end
        end
        mon_trace = '0;
        mon_len   = 0;
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ab"}, {62'd0, A, B}, 64'd0);
    check({tag, "_busy"}, {63'd0, BUSY}, 64'd0);
    check({tag, "_ready"}, {63'd0, READY}, 64'd1);
    check({tag, "_done"}, {63'd0, DONE}, 64'd0);
    check({tag, "_reject"}, {63'd0, REJECT}, 64'd0);
    check({tag, "_dir"}, {63'd0, DIR}, 64'd0);
    check({tag, "_occ"}, {61'd0, OCC}, 64'd0);
  endtask

  initial begin
    int n;
    RST_N     = 1'b0;
    REQ_ENTER = 1'b0;
    REQ_EXIT  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_idle("reset");
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Single enter then single exit.
    issue(1'b1, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 1'b1);

    // Refusals at OCC=0: exit, then both requests together.
    issue(1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b1, 1'b1);

    // Fill to the ceiling back-to-back, then an enter past it.
    for (int i = 0; i < 7; i++) issue(1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 1'b1);

    // Requests during a running sequence are ignored.
    issue(1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 1'b1);
    repeat (6) @(posedge CLK);
    #1;
    REQ_EXIT = 1'b1;
    @(posedge CLK);
    #1;
    REQ_EXIT = 1'b0;

    // Reset in PH2 aborts the sequence without a DONE.
    issue(1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge CLK);
    #1;
    check("ph2_ab", {62'd0, A, B}, 64'd3);
    check("ph2_busy", {63'd0, BUSY}, 64'd1);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    occ_m = 0;
    dir_m = 1'b0;
    check_idle("abort");
    issue(1'b1, 1'b0, 1'b1);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    @(posedge CLK);
    check("drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
